// File: rtl/router_pkg.sv
// Shared router types: port indices, route encoding, output-port lock state.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package router_pkg;

  localparam int NUM_OF_PORTS      = 5;
  localparam int NUM_OF_PORTS_BITS = $clog2(NUM_OF_PORTS);
  localparam int ROUTE_BITS        = NUM_OF_PORTS_BITS + 1;

  typedef logic [NUM_OF_PORTS_BITS-1:0] PORT_IDX_t;

  // Route MSB set means "no route"; the low bits are then don't-care.
  localparam logic [ROUTE_BITS-1:0] ROUTE_INVALID = {1'b1, {NUM_OF_PORTS_BITS{1'b0}}};

  typedef enum logic {
    OUT_FREE   = 1'b0,
    OUT_LOCKED = 1'b1
  } OUT_STATE_t;

  // A route is usable when not flagged invalid, points at an existing port,
  // and (unless U-turns are allowed) does not send a packet back where it came from.
  function automatic logic route_valid(input logic invalid, input int idx,
                                       input int self_idx, input int nports,
                                       input logic allow_uturn);
    return !invalid && (idx < nports) && (allow_uturn || (idx != self_idx));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after i_ptr (wrapping) wins.
// Latency: combinational, zero cycles.
// Backpressure: i_en low suppresses every grant; requesters simply wait.
module rr_arbiter #(
  parameter int N = 5
) (
  input  logic [N-1:0]         i_req,
  input  logic                 i_en,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_grant_idx,
  output logic                 o_any_grant
);

  localparam int IDX_W = $clog2(N);

  int w_dist;
  int w_best;

  // Pick the requester with the smallest rotational distance from the pointer.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    w_best      = N;
    w_dist      = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i + N - int'(i_ptr)) % N;
      if (i_en && i_req[i] && (w_dist < w_best)) begin
        w_best      = w_dist;
        o_grant_idx = IDX_W'(i);
      end
    end
    o_any_grant = (w_best < N);
    if (o_any_grant) o_grant[o_grant_idx] = 1'b1;
  end

endmodule

// File: rtl/switch_allocator.sv
// Switch allocator: per-output round-robin grant, output locked to winner until tail.
// Latency: request to ack 1 cycle; release (packet_done) frees output at next edge.
// Backpressure: losers and requesters of locked outputs hold req until acked.
module switch_allocator
  import router_pkg::*;
#(
  parameter int NUM_PORTS   = NUM_OF_PORTS,
  parameter int ROUTE_W     = $clog2(NUM_PORTS) + 1,
  parameter int ALLOW_UTURN = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 i_switch_req,
  input  logic [NUM_PORTS*ROUTE_W-1:0]         i_route,
  input  logic [NUM_PORTS-1:0]                 i_packet_done,
  output logic [NUM_PORTS-1:0]                 o_switch_ack,
  output logic [NUM_PORTS*$clog2(NUM_PORTS)-1:0] o_xbar_sel,
  output logic [NUM_PORTS-1:0]                 o_out_busy,
  output logic [NUM_PORTS-1:0]                 o_route_err
);

  localparam int IDX_W  = $clog2(NUM_PORTS);
  localparam int RIDX_W = ROUTE_W - 1;

  // Registered per-output state
  OUT_STATE_t                           r_state [NUM_PORTS];
  logic [NUM_PORTS-1:0][IDX_W-1:0]      r_owner;
  logic [NUM_PORTS-1:0][IDX_W-1:0]      r_ptr;
  logic [NUM_PORTS-1:0]                 r_ack;
  logic [NUM_PORTS-1:0]                 r_err;

  // Decode / arbitration wires
  logic [RIDX_W-1:0]                    w_route_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0]                 w_legal;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  w_req_mat;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  w_grant;
  logic [NUM_PORTS-1:0][IDX_W-1:0]      w_grant_idx;
  logic [NUM_PORTS-1:0]                 w_any_grant;
  logic [NUM_PORTS-1:0]                 w_out_free;
  logic [NUM_PORTS-1:0]                 w_release;
  logic [NUM_PORTS-1:0]                 w_ack_nxt;
  logic [NUM_PORTS-1:0]                 w_err_nxt;
  OUT_STATE_t                           w_state_nxt [NUM_PORTS];
  logic [NUM_PORTS-1:0][IDX_W-1:0]      w_owner_nxt;
  logic [NUM_PORTS-1:0][IDX_W-1:0]      w_ptr_nxt;

  // Decode each input's route and flag requests that can never be served.
  always_comb begin
    w_legal   = '0;
    w_err_nxt = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_route_idx[i] = i_route[i*ROUTE_W +: RIDX_W];
      w_legal[i]     = route_valid(i_route[i*ROUTE_W + RIDX_W], int'(w_route_idx[i]), i,
                                   NUM_PORTS, ALLOW_UTURN != 0);
      w_err_nxt[i]   = i_switch_req[i] && !w_legal[i];
    end
  end

  // Steer each legal request to its output; work out which outputs are free or releasing.
  always_comb begin
    w_req_mat  = '0;
    w_out_free = '0;
    w_release  = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_req_mat[o][i] = i_switch_req[i] && w_legal[i] && (int'(w_route_idx[i]) == o);
      end
      w_out_free[o] = (r_state[o] == OUT_FREE);
      // Only the current owner's tail pulse can release the output.
      w_release[o]  = (r_state[o] == OUT_LOCKED) && i_packet_done[r_owner[o]];
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
    rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .i_req       (w_req_mat[g]),
      .i_en        (w_out_free[g]),
      .i_ptr       (r_ptr[g]),
      .o_grant     (w_grant[g]),
      .o_grant_idx (w_grant_idx[g]),
      .o_any_grant (w_any_grant[g])
    );
  end

  // Per-output FREE/LOCKED next state, owner, pointer; merge grants into per-input acks.
  always_comb begin
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_ack_nxt   = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_state_nxt[o] = r_state[o];
      if (w_any_grant[o]) begin
        w_state_nxt[o] = OUT_LOCKED;
        w_owner_nxt[o] = w_grant_idx[o];
        w_ptr_nxt[o]   = (w_grant_idx[o] == IDX_W'(NUM_PORTS-1)) ? '0
                                                                 : w_grant_idx[o] + IDX_W'(1);
      end else if (w_release[o]) begin
        w_state_nxt[o] = OUT_FREE;
      end
      // Each input routes to one output, so these ORs never overlap.
      w_ack_nxt = w_ack_nxt | w_grant[o];
    end
  end

  // State, owner, pointer, ack and error registers; reset wins even mid-packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < NUM_PORTS; o++) r_state[o] <= OUT_FREE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_ack   <= '0;
      r_err   <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) r_state[o] <= w_state_nxt[o];
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Crossbar select is only meaningful while the matching busy bit is set.
  always_comb begin
    o_xbar_sel = '0;
    o_out_busy = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      o_xbar_sel[o*IDX_W +: IDX_W] = r_owner[o];
      o_out_busy[o]                = (r_state[o] == OUT_LOCKED);
    end
  end

  assign o_switch_ack = r_ack;
  assign o_route_err  = r_err;

  // Sanity checks: one grant per output, grants only to live requests, one output per owner.
  always @(posedge clk) begin
    if (!reset) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        a_one_grant: assert ($onehot0(w_grant[o]));
        for (int p = o + 1; p < NUM_PORTS; p++) begin
          a_one_owner: assert (!((r_state[o] == OUT_LOCKED) && (r_state[p] == OUT_LOCKED)
                                 && (r_owner[o] == r_owner[p])));
        end
      end
      a_ack_has_req: assert ((w_ack_nxt & ~i_switch_req) == '0);
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios with literal checks plus a per-cycle model compare.
// Latency: model predicts registered outputs one cycle after the inputs it saw.
// Backpressure: stimulus holds requests until acked, as input units do.
module tb_switch_allocator;
  import router_pkg::*;

  localparam int NP = 5;
  localparam int RW = 4;
  localparam int IW = 3;

  logic              clk;
  logic              reset;
  logic [NP-1:0]     req;
  logic [NP*RW-1:0]  route;
  logic [NP-1:0]     done;
  logic [NP-1:0]     ack;
  logic [NP*IW-1:0]  sel;
  logic [NP-1:0]     busy;
  logic [NP-1:0]     err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Model state
  bit            m_locked [NP];
  int            m_owner  [NP];
  int            m_ptr    [NP];
  logic [NP-1:0] m_ack = '0;
  logic [NP-1:0] m_err = '0;

  int exp_order [4] = '{1, 3, 4, 1};

  switch_allocator #(.NUM_PORTS(NP), .ROUTE_W(RW), .ALLOW_UTURN(0)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_switch_req  (req),
    .i_route       (route),
    .i_packet_done (done),
    .o_switch_ack  (ack),
    .o_xbar_sel    (sel),
    .o_out_busy    (busy),
    .o_route_err   (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int o = 0; o < NP; o++) begin
      m_locked[o] = 0;
      m_owner[o]  = 0;
      m_ptr[o]    = 0;
    end
  end

  function automatic bit legal(input int i, input logic [RW-1:0] r);
    int idx;
    idx = int'(r[RW-2:0]);
    return (r[RW-1] == 1'b0) && (idx < NP) && (idx != i);
  endfunction

  function automatic logic [IW-1:0] sel_of(input int o);
    return sel[o*IW +: IW];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_route(input int i, input logic [RW-1:0] r);
    route[i*RW +: RW] = r;
  endtask

  // Reference model: scan each free output from its pointer, first legal requester wins.
  always @(posedge clk) begin : model
    logic [NP-1:0] nack;
    logic [NP-1:0] nerr;
    logic [RW-1:0] r;
    int            c;
    bit            won;
    if (reset) begin
      for (int o = 0; o < NP; o++) begin
        m_locked[o] <= 0;
        m_owner[o]  <= 0;
        m_ptr[o]    <= 0;
      end
      m_ack <= '0;
      m_err <= '0;
    end else begin
      nack = '0;
      nerr = '0;
      for (int i = 0; i < NP; i++) begin
        r = route[i*RW +: RW];
        if (req[i] && !legal(i, r)) nerr[i] = 1'b1;
      end
      for (int o = 0; o < NP; o++) begin
        if (!m_locked[o]) begin
          won = 0;
          for (int k = 0; k < NP; k++) begin
            c = (m_ptr[o] + k) % NP;
            r = route[c*RW +: RW];
            if (!won && req[c] && legal(c, r) && (int'(r[RW-2:0]) == o)) begin
              won         = 1;
              nack[c]     = 1'b1;
              m_locked[o] <= 1;
              m_owner[o]  <= c;
              m_ptr[o]    <= (c + 1) % NP;
            end
          end
        end else if (done[m_owner[o]]) begin
          m_locked[o] <= 0;
        end
      end
      m_ack <= nack;
      m_err <= nerr;
    end
  end

  // Every cycle, compare all DUT outputs against the model mid-cycle.
  always @(negedge clk) begin : cmp
    logic [NP-1:0]    eb;
    logic [NP*IW-1:0] es;
    if (chk_en) begin
      eb = '0;
      es = '0;
      for (int o = 0; o < NP; o++) begin
        eb[o]          = m_locked[o];
        es[o*IW +: IW] = IW'(m_owner[o]);
      end
      check("model_ack",  ack,  m_ack);
      check("model_err",  err,  m_err);
      check("model_busy", busy, eb);
      check("model_sel",  sel,  es);
    end
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    route = '0;
    done  = '0;

    // Reset state
    step();
    chk_en = 1;
    step();
    check("reset_ack",  ack,  0);
    check("reset_busy", busy, 0);
    check("reset_sel",  sel,  0);
    check("reset_err",  err,  0);

    // Single request: in0 -> out2, ack one cycle only, release by packet_done
    reset = 1'b0;
    req   = 5'b00001;
    set_route(0, 4'd2);
    step();
    check("single_ack",  ack, 5'b00001);
    check("single_busy", busy, 5'b00100);
    check("single_sel2", sel_of(2), 0);
    step();
    check("single_ack_once", ack, 0);
    check("single_busy_held", busy, 5'b00100);
    req  = '0;
    done = 5'b00001;
    step();
    done = '0;
    check("single_release", busy, 0);

    // Round-robin contention on out0 from inputs 1, 3, 4
    set_route(1, 4'd0);
    set_route(3, 4'd0);
    set_route(4, 4'd0);
    req = 5'b11010;
    for (int n = 0; n < 4; n++) begin
      int w;
      w = 0;
      do begin
        step();
        w++;
      end while (ack == '0 && w < 8);
      check("rr_ack", ack, 32'd1 << exp_order[n]);
      check("rr_sel0", sel_of(0), exp_order[n]);
      if (n == 3) req = '0;
      repeat (2) step();
      done[exp_order[n]] = 1'b1;
      step();
      done = '0;
    end
    route = '0;

    // Parallel grants: in0 -> out3, in2 -> out1
    set_route(0, 4'd3);
    set_route(2, 4'd1);
    req = 5'b00101;
    step();
    check("par_ack",  ack, 5'b00101);
    check("par_sel3", sel_of(3), 0);
    check("par_sel1", sel_of(1), 2);
    check("par_busy", busy, 5'b01010);
    req  = '0;
    done = 5'b00101;
    step();
    done = '0;
    check("par_release", busy, 0);

    // Release and request in the same cycle on out0
    set_route(1, 4'd0);
    req = 5'b00010;
    step();
    check("rel_first_ack", ack, 5'b00010);
    req = '0;
    step();
    set_route(2, 4'd0);
    req  = 5'b00100;
    done = 5'b00010;
    step();
    done = '0;
    check("rel_no_early_ack", ack, 0);
    step();
    check("rel_ack_t2", ack, 5'b00100);
    check("rel_sel0", sel_of(0), 2);
    req  = '0;
    done = 5'b01000;
    step();
    done = '0;
    check("spurious_busy0", busy[0], 1);
    check("spurious_sel0", sel_of(0), 2);
    // Owner releases out0 while requesting out4 in the same cycle
    set_route(2, 4'd4);
    req  = 5'b00100;
    done = 5'b00100;
    step();
    done = '0;
    req  = '0;
    check("swap_ack",  ack, 5'b00100);
    check("swap_busy", busy, 5'b10000);
    done = 5'b00100;
    step();
    done = '0;
    check("swap_release", busy, 0);

    // Illegal routes: invalid flag, index out of range, U-turn; in3 -> out1 legal
    set_route(0, ROUTE_INVALID);
    set_route(1, 4'd6);
    set_route(2, 4'd2);
    set_route(3, 4'd1);
    req = 5'b01111;
    step();
    check("ill_err",  err, 5'b00111);
    check("ill_ack",  ack, 5'b01000);
    check("ill_busy", busy, 5'b00010);
    step();
    check("ill_err_held", err, 5'b00111);
    check("ill_no_ack", ack, 0);
    req = '0;
    step();
    check("ill_err_clear", err, 0);
    done = 5'b01000;
    step();
    done  = '0;
    route = '0;

    // Reset mid-packet with a pending request
    set_route(0, 4'd1);
    req = 5'b00001;
    step();
    check("rst_pre_ack", ack, 5'b00001);
    set_route(4, 4'd1);
    req = 5'b10000;
    step();
    reset = 1'b1;
    step();
    check("rst_busy", busy, 0);
    check("rst_ack",  ack, 0);
    reset = 1'b0;
    step();
    check("rst_regrant_ack", ack, 5'b10000);
    check("rst_regrant_sel1", sel_of(1), 4);
    req  = '0;
    done = 5'b10000;
    step();
    done = '0;
    step();

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
